// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the SDRAM command-port arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    localparam int AW_DEF = 24;
    localparam int DW_DEF = 16;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel,
    output logic       valid
);

    always_comb begin
        valid = |req;
        sel   = 1'(PORT_CPU);
        // On a tie the port that was not served last wins
        if (req == 2'b11) begin
            sel = ~last;
        end else if (req[PORT_DMA]) begin
            sel = 1'(PORT_DMA);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and sequencer for the SDRAM controller command port
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic          clki,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [1:0]    err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] sd_addr,
    output logic [DW-1:0] sd_wdata,
    output logic          sd_read,
    output logic          sd_write,
    input  logic [DW-1:0] sd_rdata,
    input  logic          sd_busy,
    input  logic          sd_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;

    logic          pick_sel;
    logic          pick_valid;
    logic          complete;

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_q),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    // A ready seen in the first WAIT cycle may be left over from the previous access
    assign complete = (cnt_q != '0) && sd_ready && !sd_busy;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d          = pick_sel;
                    we_d           = we[pick_sel];
                    addr_d         = pick_sel ? addr1 : addr0;
                    wdata_d        = pick_sel ? wdata1 : wdata0;
                    last_d         = pick_sel;
                    gnt_d[pick_sel] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (!sd_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (complete) begin
                    if (!we_q) begin
                        rdata_d = sd_rdata;
                    end
                    done_d[sel_q] = 1'b1;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d       = '0;
                    done_d[sel_q] = 1'b1;
                    err_d[sel_q]  = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once
    assign sd_read  = (state_q == ISSUE) && !we_q;
    assign sd_write = (state_q == ISSUE) &&  we_q;

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign sd_addr  = addr_q;
    assign sd_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [23:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt, done, err;
    logic [15:0] rdata;
    logic [23:0] sd_addr;
    logic [15:0] sd_wdata;
    logic        sd_read, sd_write;
    logic [15:0] sd_rdata;
    logic        sd_busy, sd_ready;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.AW(24), .DW(16), .TIMEOUT(15)) dut (
        .clki     (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .sd_addr  (sd_addr),
        .sd_wdata (sd_wdata),
        .sd_read  (sd_read),
        .sd_write (sd_write),
        .sd_rdata (sd_rdata),
        .sd_busy  (sd_busy),
        .sd_ready (sd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [23:0] a0;
        logic [23:0] a1;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] rd;
        int          dly;
        logic [1:0]  e_gnt;
        logic [1:0]  e_strb;
        logic [23:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 32'(gnt), 32'h1);
    endtask

    task automatic wait_done(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (done != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int n;
        req      = v.req;
        we       = v.we;
        addr0    = v.a0;
        addr1    = v.a1;
        wdata0   = v.w0;
        wdata1   = v.w1;
        sd_rdata = v.rd;
        sd_ready = 1'b0;
        sd_busy  = 1'b0;
        wait_gnt(ok);
        if (ok) begin
            chk($sformatf("v%0d_gnt", idx), 32'(gnt), 32'(v.e_gnt));
            chk($sformatf("v%0d_strobe", idx), 32'({sd_write, sd_read}), 32'(v.e_strb));
            chk($sformatf("v%0d_sd_addr", idx), 32'(sd_addr), 32'(v.e_addr));
            chk($sformatf("v%0d_sd_wdata", idx), 32'(sd_wdata), 32'(v.e_wdata));
            req = req & ~gnt;
            tick();
            chk($sformatf("v%0d_gnt_pulse", idx), 32'(gnt), 32'h0);
            repeat (v.dly) tick();
            sd_ready = 1'b1;
            wait_done(ok, n);
            if (ok) begin
                chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.e_gnt));
                chk($sformatf("v%0d_err", idx), 32'(err), 32'h0);
                chk($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.e_rdata));
            end
            sd_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int n;
        bit saw_done;
        vec_t extra;

        //        req    we     a0         a1          w0        w1        rd        dly gnt    strb   addr        wdata     rdata
        vecs[0] = '{2'b11, 2'b01, 24'h10,    24'h20,     16'h1234, 16'h0000, 16'hDEAD, 1, 2'b01, 2'b10, 24'h10,     16'h1234, 16'h0000};
        vecs[1] = '{2'b10, 2'b01, 24'h10,    24'h20,     16'h1234, 16'h0000, 16'h5A5A, 0, 2'b10, 2'b01, 24'h20,     16'h0000, 16'h5A5A};
        vecs[2] = '{2'b01, 2'b00, 24'h100,   24'h0,      16'h0000, 16'h0000, 16'hBEEF, 1, 2'b01, 2'b01, 24'h100,    16'h0000, 16'hBEEF};
        vecs[3] = '{2'b11, 2'b00, 24'h200,   24'h300,    16'h0000, 16'h0000, 16'h1111, 2, 2'b10, 2'b01, 24'h300,    16'h0000, 16'h1111};
        vecs[4] = '{2'b01, 2'b00, 24'h200,   24'h300,    16'h0000, 16'h0000, 16'h2222, 0, 2'b01, 2'b01, 24'h200,    16'h0000, 16'h2222};
        vecs[5] = '{2'b10, 2'b10, 24'h0,     24'hABCDEF, 16'h0000, 16'hCAFE, 16'hFFFF, 1, 2'b10, 2'b10, 24'hABCDEF, 16'hCAFE, 16'h2222};
        vecs[6] = '{2'b11, 2'b11, 24'h400,   24'h500,    16'h7777, 16'h8888, 16'hFFFF, 3, 2'b01, 2'b10, 24'h400,    16'h7777, 16'h2222};

        rst_n    = 1'b0;
        req      = '0;
        we       = '0;
        addr0    = '0;
        addr1    = '0;
        wdata0   = '0;
        wdata1   = '0;
        sd_rdata = '0;
        sd_busy  = 1'b0;
        sd_ready = 1'b0;
        #23;
        chk("reset_pulses", 32'({gnt, done, err}), 32'h0);
        chk("reset_strobes", 32'({sd_write, sd_read}), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_sd_addr", 32'(sd_addr), 32'h0);
        chk("reset_sd_wdata", 32'(sd_wdata), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        req = 2'b00;

        // Stale ready held across the accept: done must wait for the counter
        sd_ready = 1'b1;
        sd_rdata = 16'h3333;
        req      = 2'b01;
        we       = 2'b00;
        addr0    = 24'h500;
        wait_gnt(ok);
        if (ok) begin
            req = 2'b00;
            tick();
            chk("stale_done_e1", 32'(done), 32'h0);
            tick();
            chk("stale_done_e2", 32'(done), 32'h0);
            tick();
            chk("stale_done_e3", 32'(done), 32'h1);
            chk("stale_rdata", 32'(rdata), 32'h3333);
        end
        sd_ready = 1'b0;
        req      = 2'b00;

        // Timeout: controller never signals ready
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 24'h600;
        wait_gnt(ok);
        if (ok) begin
            req = 2'b00;
            tick();
            wait_done(ok, n);
            if (ok) begin
                chk("to_latency", 32'(n), 32'd16);
                chk("to_done", 32'(done), 32'h1);
                chk("to_err", 32'(err), 32'h1);
                chk("to_rdata", 32'(rdata), 32'h0);
                tick();
                chk("to_err_pulse", 32'(err), 32'h0);
            end
        end
        req = 2'b00;

        extra = '{2'b01, 2'b00, 24'h610, 24'h0, 16'h0, 16'h0, 16'h4444, 1, 2'b01, 2'b01, 24'h610, 16'h0, 16'h4444};
        run_vec(extra, 7);
        req = 2'b00;

        // Busy stall: ISSUE holds for five busy edges plus the accepting edge
        sd_busy  = 1'b1;
        sd_rdata = 16'h5555;
        req      = 2'b01;
        we       = 2'b00;
        addr0    = 24'h700;
        wait_gnt(ok);
        if (ok) begin
            req = 2'b00;
            n   = int'(sd_read);
            repeat (5) begin
                tick();
                n += int'(sd_read);
                if (done != 2'b00) n += 100;
            end
            sd_busy = 1'b0;
            tick();
            chk("busy_read_cycles", 32'(n), 32'd6);
            chk("busy_read_dropped", 32'(sd_read), 32'h0);
            sd_ready = 1'b1;
            wait_done(ok, n);
            if (ok) begin
                chk("busy_done", 32'(done), 32'h1);
                chk("busy_rdata", 32'(rdata), 32'h5555);
            end
            sd_ready = 1'b0;
        end
        req     = 2'b00;
        sd_busy = 1'b0;

        // Asynchronous reset in the middle of a transaction
        sd_busy = 1'b1;
        req     = 2'b10;
        we      = 2'b10;
        addr1   = 24'h800;
        wdata1  = 16'h9999;
        wait_gnt(ok);
        if (ok) begin
            chk("rst_pre_write", 32'(sd_write), 32'h1);
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_strobes", 32'({sd_write, sd_read}), 32'h0);
            chk("rst_pulses", 32'({gnt, done, err}), 32'h0);
            chk("rst_sd_addr", 32'(sd_addr), 32'h0);
            chk("rst_sd_wdata", 32'(sd_wdata), 32'h0);
            chk("rst_rdata", 32'(rdata), 32'h0);
        end
        req     = 2'b00;
        sd_busy = 1'b0;
        tick();
        rst_n    = 1'b1;
        sd_ready = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            if (done != 2'b00) saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'h0);
        sd_ready = 1'b0;
        req      = 2'b11;
        we       = 2'b00;
        tick();
        chk("rst_tie_port0", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
